uart_tx_buffered: RTL and testbench
===================================

UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

Interface
REQ-001 SHALL have parameter DATA_W, default 9, maximum data bits per frame (5..9).
REQ-002 SHALL have parameter DEPTH, default 16, transmit FIFO depth in words (power of 2, >=2).
REQ-003 SHALL have parameter DIV_W, default 16, width of the baud divider.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 uart_en  in  1  block enable; low flushes the FIFO and aborts any frame.
REQ-007 tx_en  in  1  permits new frames to start.
REQ-008 n_parity_bits  in  1  0 = no parity, 1 = one parity bit.
REQ-009 parity_odd  in  1  0 = even parity, 1 = odd parity.
REQ-010 n_stop_bits  in  2  stop bit count.
REQ-011 n_data_bits  in  4  data bits per frame.
REQ-012 clk_divider  in  DIV_W  bit period minus one, in clk cycles.
REQ-013 in_dat  in  DATA_W  word to transmit, LSB-aligned.
REQ-014 in_vld  in  1  in_dat valid.
REQ-015 in_rdy  out  1  FIFO can accept a word.
REQ-016 tx  out  1  serial line, idle high, registered.
REQ-017 busy  out  1  frame in progress.
REQ-018 fifo_level  out  $clog2(DEPTH)+1  number of words stored.

Function
REQ-019 SHALL accept a word on any rising edge where in_vld and in_rdy are both high.
REQ-020 SHALL drive in_rdy = uart_en AND (fifo_level < DEPTH), where fifo_level is the registered count; a word offered while full is refused even if a pop occurs in the same cycle.
REQ-021 SHALL implement the FSM states IDLE, START, DATA, PARITY, STOP.
REQ-022 IDLE->START when uart_en, tx_en and fifo_level>0, popping the FIFO head; tx SHALL go low on the first rising edge after the edge that made the FIFO non-empty.
REQ-023 SHALL hold each bit for clk_divider+1 cycles (clk_divider=0 -> 1 cycle/bit).
REQ-024 SHALL transmit data LSB first in DATA, followed by PARITY (only if n_parity_bits=1), then STOP (tx=1).
REQ-025 SHALL clamp n_data_bits: values <5 are treated as 5; values >DATA_W are treated as DATA_W.
REQ-026 SHALL treat n_stop_bits 0 as 1 stop bit and 3 as 2 stop bits.
REQ-027 SHALL compute the parity bit as the XOR of the transmitted data bits, inverted when parity_odd=1.
REQ-028 SHALL latch all configuration inputs and the popped word at START entry; configuration changes mid-frame SHALL NOT affect the current frame.
REQ-029 Frame length SHALL be (1+data+parity+stop)*(clk_divider+1) cycles.
REQ-030 At the end of STOP, if start conditions hold, SHALL go directly to START with no idle gap; otherwise SHALL go to IDLE.
REQ-031 When tx_en falls mid-frame, SHALL complete the current frame, then remain IDLE; the FIFO SHALL still accept words.
REQ-032 When uart_en is low at a clock edge, SHALL synchronously empty the FIFO, enter IDLE, and drive tx=1 and busy=0 from the next cycle.
REQ-033 busy SHALL be high exactly when the FSM is not in IDLE.
REQ-034 A simultaneous write and pop SHALL leave fifo_level unchanged; the FIFO pointers SHALL wrap modulo DEPTH.

Reset
REQ-035 When rst is low, SHALL asynchronously set tx=1, busy=0, fifo_level=0, the FSM to IDLE, the FIFO pointers to 0, and the bit counters to 0.
REQ-036 During reset, in_rdy SHALL equal uart_en.
REQ-037 Reset asserted mid-frame SHALL abort the frame and discard all FIFO contents.

Verification
REQ-038 Setup div=3, 8N1, write 0xA5 -> tx = 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles, 40 cycles total; busy then falls.
REQ-039 Setup DATA_W=9, 9 data bits, odd parity, 2 stop, div=0, write 0x1FF -> 13 bits: 0, nine 1s, parity 0, 1, 1.
REQ-040 tx_en=0, write 17 words -> in_rdy low after 16, fifo_level=16; set tx_en=1 -> 16 frames back-to-back, no idle gap, level decrements at each START.
REQ-041 Drop uart_en mid-DATA with 5 words queued -> next cycle tx=1, busy=0, fifo_level=0; restore uart_en -> no frame starts.
REQ-042 Set n_data_bits=3, even parity, write 0x1F -> 5 data bits 1,1,1,1,1 and parity bit 1 are sent.
REQ-043 Assert rst mid-STOP of the 2nd of 3 frames -> tx=1 and fifo_level=0 immediately, with no clock edge required.

Source files
------------

// File: rtl/uart_tx_buffered.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_buffered
// Brief    : UART transmitter fed by a word FIFO with run-time frame format.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_buffered #(
    parameter int DATA_W = 9,
    parameter int DEPTH  = 16,
    parameter int DIV_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     uart_en,
    input  logic                     tx_en,
    input  logic                     n_parity_bits,
    input  logic                     parity_odd,
    input  logic [1:0]               n_stop_bits,
    input  logic [3:0]               n_data_bits,
    input  logic [DIV_W-1:0]         clk_divider,
    input  logic [DATA_W-1:0]        in_dat,
    input  logic                     in_vld,
    output logic                     in_rdy,
    output logic                     tx,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_level
);
    localparam int                c_AW    = $clog2(DEPTH);
    localparam logic [c_AW:0]     c_FULL  = (c_AW + 1)'(DEPTH);
    localparam logic [3:0]        c_DW4   = 4'(DATA_W);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_PARITY = 3'd3;
    localparam logic [2:0] c_STOP   = 3'd4;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [c_AW:0]     r_level;

    logic [2:0]        r_state, w_state_nxt;
    logic [DIV_W-1:0]  r_div, r_baud;
    logic [3:0]        r_bit, r_nbits, w_nbits_clamp;
    logic              r_nstop2, r_par_en, r_par_bit, r_tx, w_tx_nxt;
    logic [DATA_W-1:0] r_shift, w_shift_nxt, w_head_masked;
    logic              w_push, w_pop, w_can_start, w_tick, w_last_data, w_last_stop;

    assign in_rdy      = uart_en && (r_level < c_FULL);
    assign w_push      = in_vld && in_rdy;
    assign w_can_start = uart_en && tx_en && (r_level != '0);
    assign w_tick      = (r_baud == r_div);
    assign w_last_data = (r_bit == r_nbits - 4'd1);
    assign w_last_stop = (r_bit == {3'b000, r_nstop2});

    assign tx         = r_tx;
    assign busy       = (r_state != c_IDLE);
    assign fifo_level = r_level;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_dat;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (!uart_en) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Format inputs are sampled only when a word is popped, so they are
    // evaluated here against the live configuration.
    always_comb begin
        if (n_data_bits < 4'd5)       w_nbits_clamp = 4'd5;
        else if (n_data_bits > c_DW4) w_nbits_clamp = c_DW4;
        else                          w_nbits_clamp = n_data_bits;
        w_head_masked = r_mem[r_rd_ptr];
        for (int i = 0; i < DATA_W; i++) begin
            if (i >= int'(w_nbits_clamp)) w_head_masked[i] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_can_start) begin
                    w_state_nxt = c_START;
                    w_pop       = 1'b1;
                end
            end
            c_START:  if (w_tick) w_state_nxt = c_DATA;
            c_DATA:   if (w_tick && w_last_data) w_state_nxt = r_par_en ? c_PARITY : c_STOP;
            c_PARITY: if (w_tick) w_state_nxt = c_STOP;
            c_STOP: begin
                if (w_tick && w_last_stop) begin
                    w_state_nxt = w_can_start ? c_START : c_IDLE;
                    w_pop       = w_can_start;
                end
            end
            default:  w_state_nxt = c_IDLE;
        endcase
        if (!uart_en) begin
            w_state_nxt = c_IDLE;
            w_pop       = 1'b0;
        end
    end

    // tx is registered from the next state so the line follows the FSM without lag.
    always_comb begin
        w_shift_nxt = r_shift;
        if (w_pop) begin
            w_shift_nxt = r_mem[r_rd_ptr];
        end else if (r_state == c_DATA && w_tick) begin
            w_shift_nxt = r_shift >> 1;
        end
        case (w_state_nxt)
            c_START:  w_tx_nxt = 1'b0;
            c_DATA:   w_tx_nxt = w_shift_nxt[0];
            c_PARITY: w_tx_nxt = r_par_bit;
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx      <= 1'b1;
            r_shift   <= '0;
            r_baud    <= '0;
            r_bit     <= '0;
            r_div     <= '0;
            r_nbits   <= 4'd5;
            r_nstop2  <= 1'b0;
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
        end else begin
            r_tx    <= w_tx_nxt;
            r_shift <= w_shift_nxt;
            if (w_pop) begin
                r_div     <= clk_divider;
                r_nbits   <= w_nbits_clamp;
                r_nstop2  <= n_stop_bits[1];
                r_par_en  <= n_parity_bits;
                r_par_bit <= (^w_head_masked) ^ parity_odd;
            end
            if (r_state == c_IDLE || w_state_nxt != r_state) begin
                r_baud <= '0;
                r_bit  <= '0;
            end else if (w_tick) begin
                r_baud <= '0;
                r_bit  <= r_bit + 4'd1;
            end else begin
                r_baud <= r_baud + 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_uart_tx_buffered.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_buffered
// Brief    : Scoreboard bench; a line monitor decodes frames against a model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_tx_buffered;
    localparam int DATA_W = 9;
    localparam int DEPTH  = 16;
    localparam int DIV_W  = 16;

    logic              clk = 1'b0;
    logic              rst, uart_en, tx_en, n_parity_bits, parity_odd;
    logic [1:0]        n_stop_bits;
    logic [3:0]        n_data_bits;
    logic [DIV_W-1:0]  clk_divider;
    logic [DATA_W-1:0] in_dat;
    logic              in_vld, in_rdy, tx, busy;
    logic [4:0]        fifo_level;

    uart_tx_buffered #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
        .clk(clk), .rst(rst), .uart_en(uart_en), .tx_en(tx_en),
        .n_parity_bits(n_parity_bits), .parity_odd(parity_odd),
        .n_stop_bits(n_stop_bits), .n_data_bits(n_data_bits),
        .clk_divider(clk_divider), .in_dat(in_dat), .in_vld(in_vld),
        .in_rdy(in_rdy), .tx(tx), .busy(busy), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bits;
        int          len;
        int          div;
    } frame_t;

    frame_t      exp_q[$];
    int          n_pass = 0;
    int          n_total = 0;
    int          flush_req = 0;
    logic [15:0] last_cap = '0;

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Expected line sequence, one entry per bit period, start bit at index 0.
    function automatic frame_t model_frame(input logic [DATA_W-1:0] w);
        frame_t f;
        int     nb, ns, k;
        logic   p;
        nb = int'(n_data_bits);
        if (nb < 5) nb = 5;
        if (nb > DATA_W) nb = DATA_W;
        ns = (n_stop_bits >= 2'd2) ? 2 : 1;
        f.bits = '0;
        k = 1;
        p = 1'b0;
        for (int i = 0; i < nb; i++) begin
            f.bits[k] = w[i];
            p = p ^ w[i];
            k++;
        end
        if (n_parity_bits) begin
            f.bits[k] = p ^ parity_odd;
            k++;
        end
        for (int i = 0; i < ns; i++) begin
            f.bits[k] = 1'b1;
            k++;
        end
        f.len = k;
        f.div = int'(clk_divider);
        return f;
    endfunction

    // Line monitor: every cycle of every bit must match the first sample of it.
    int          mon_flush_seen = 0;
    bit          in_frame = 1'b0;
    bit          bad = 1'b0;
    frame_t      cur;
    int          cyc_in_bit = 0;
    int          bit_idx = 0;
    logic [15:0] cap = '0;

    always @(negedge clk) begin
        if (flush_req != mon_flush_seen) begin
            mon_flush_seen = flush_req;
            in_frame = 1'b0;
        end else begin
            if (!in_frame && rst === 1'b1 && tx === 1'b0) begin
                check(exp_q.size() > 0, "frame_expected", exp_q.size(), 1);
                if (exp_q.size() > 0) begin
                    cur = exp_q.pop_front();
                    in_frame = 1'b1;
                    cyc_in_bit = 0;
                    bit_idx = 0;
                    bad = 1'b0;
                    cap = '0;
                end
            end
            if (in_frame) begin
                if (cyc_in_bit == 0) cap[bit_idx] = tx;
                else if (tx !== cap[bit_idx]) bad = 1'b1;
                cyc_in_bit++;
                if (cyc_in_bit > cur.div) begin
                    cyc_in_bit = 0;
                    bit_idx++;
                    if (bit_idx == cur.len) begin
                        check(!bad && cap == cur.bits, "frame_bits", {bad, cap}, cur.bits);
                        last_cap = cap;
                        in_frame = 1'b0;
                    end
                end
            end
        end
    end

    task automatic send(input logic [DATA_W-1:0] w, input int max_wait, output bit acc);
        in_dat = w;
        in_vld = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < max_wait && !acc; i++) begin
            if (in_rdy) begin
                acc = 1'b1;
                exp_q.push_back(model_frame(w));
            end
            @(negedge clk);
        end
        in_vld = 1'b0;
    endtask

    task automatic busy_run(output int n);
        n = 0;
        while (busy && n < 5000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic single_frame(input logic [DATA_W-1:0] w, input logic [15:0] exp_bits,
                                input int exp_cyc, input string name);
        bit acc;
        int n;
        send(w, 4, acc);
        check(acc, {name, "_accept"}, acc, 1);
        check(tx === 1'b1 && busy === 1'b0, {name, "_no_early_start"}, {tx, busy}, 2'b10);
        @(negedge clk);
        check(tx === 1'b0, {name, "_start_latency"}, tx, 0);
        busy_run(n);
        check(n == exp_cyc, {name, "_frame_cycles"}, n, exp_cyc);
        check(last_cap == exp_bits, {name, "_line_bits"}, last_cap, exp_bits);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        bit acc;
        int n, t, n_acc, any_busy;
        rst = 1'b0; uart_en = 1'b1; tx_en = 1'b0;
        n_parity_bits = 1'b0; parity_odd = 1'b0; n_stop_bits = 2'd1; n_data_bits = 4'd8;
        clk_divider = 16'd3; in_dat = '0; in_vld = 1'b0;

        #12;
        check(in_rdy === 1'b1, "rst_in_rdy_en1", in_rdy, 1);
        uart_en = 1'b0;
        #1;
        check(in_rdy === 1'b0, "rst_in_rdy_en0", in_rdy, 0);
        check(tx === 1'b1, "rst_tx", tx, 1);
        check(busy === 1'b0, "rst_busy", busy, 0);
        check(fifo_level === 5'd0, "rst_level", fifo_level, 0);
        @(negedge clk);
        rst = 1'b1; uart_en = 1'b1; tx_en = 1'b1;
        repeat (2) @(negedge clk);

        // 8N1, divider 3
        single_frame(9'h0A5, 16'h034A, 40, "a5_8n1");
        // 9 data bits, odd parity, 2 stop, divider 0
        clk_divider = 16'd0; n_data_bits = 4'd9; n_parity_bits = 1'b1; parity_odd = 1'b1; n_stop_bits = 2'd2;
        single_frame(9'h1FF, 16'h1BFE, 13, "1ff_9o2");
        // 3 data bits clamps to 5, even parity, stop code 0 means one stop
        clk_divider = 16'd1; n_data_bits = 4'd3; parity_odd = 1'b0; n_stop_bits = 2'd0;
        single_frame(9'h01F, 16'h00FE, 16, "1f_clamp5");

        // Fill the FIFO while transmission is held off, then release it
        clk_divider = 16'd1; n_data_bits = 4'd8; n_parity_bits = 1'b0; n_stop_bits = 2'd1;
        tx_en = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 16; i++) begin
            send(9'($urandom_range(0, 255)), 2, acc);
            if (acc) n_acc++;
        end
        check(n_acc == 16, "fill_accepts", n_acc, 16);
        send(9'h155, 3, acc);
        check(!acc, "full_refuses", acc, 0);
        check(fifo_level === 5'd16, "full_level", fifo_level, 16);
        check(in_rdy === 1'b0, "full_in_rdy", in_rdy, 0);
        tx_en = 1'b1;
        @(negedge clk);
        n = 0;
        while (busy && n < 5000) begin
            n++;
            if (n == 1)  check(fifo_level === 5'd15, "level_first_start", fifo_level, 15);
            if (n == 21) check(fifo_level === 5'd14, "level_second_start", fifo_level, 14);
            @(negedge clk);
        end
        check(n == 320, "back_to_back_cycles", n, 320);

        // Disable mid-DATA with five words queued
        clk_divider = 16'd3;
        for (int i = 0; i < 6; i++) send(9'($urandom_range(0, 255)), 2, acc);
        repeat (4) @(negedge clk);
        check(fifo_level === 5'd5 && busy === 1'b1, "pre_flush", {busy, fifo_level}, 6'h25);
        uart_en = 1'b0;
        exp_q.delete();
        flush_req++;
        @(negedge clk);
        check(tx === 1'b1 && busy === 1'b0 && fifo_level === 5'd0, "flush_state",
              {tx, busy, fifo_level}, 7'h40);
        uart_en = 1'b1;
        any_busy = 0;
        repeat (50) begin
            @(negedge clk);
            if (busy) any_busy = 1;
        end
        check(any_busy == 0, "no_start_after_flush", any_busy, 0);

        // Asynchronous reset during the stop bit of the second of three frames
        for (int i = 0; i < 3; i++) send(9'($urandom_range(0, 255)), 2, acc);
        repeat (76) @(negedge clk);
        check(busy === 1'b1 && tx === 1'b1 && fifo_level === 5'd1, "pre_reset",
              {busy, tx, fifo_level}, 7'h61);
        #2;
        rst = 1'b0;
        exp_q.delete();
        flush_req++;
        #1;
        check(tx === 1'b1 && busy === 1'b0 && fifo_level === 5'd0, "async_reset",
              {tx, busy, fifo_level}, 7'h40);
        @(negedge clk);
        rst = 1'b1;
        any_busy = 0;
        repeat (60) begin
            @(negedge clk);
            if (busy) any_busy = 1;
        end
        check(any_busy == 0, "no_frame_after_reset", any_busy, 0);

        // Random formats; format changes while the last frame of a batch is in flight
        for (int b = 0; b < 8; b++) begin
            clk_divider   = 16'($urandom_range(0, 3));
            n_data_bits   = 4'($urandom_range(0, 15));
            n_parity_bits = 1'($urandom_range(0, 1));
            parity_odd    = 1'($urandom_range(0, 1));
            n_stop_bits   = 2'($urandom_range(0, 3));
            repeat ($urandom_range(3, 6)) begin
                send(9'($urandom_range(0, 511)), 400, acc);
                check(acc, "rand_accept", acc, 1);
                repeat ($urandom_range(0, 5)) @(negedge clk);
            end
            t = 0;
            while (fifo_level != 5'd0 && t < 2000) begin
                t++;
                @(negedge clk);
            end
            check(t < 2000, "rand_fifo_drain", t, 2000);
        end

        t = 0;
        while ((exp_q.size() != 0 || busy) && t < 20000) begin
            t++;
            @(negedge clk);
        end
        check(t < 20000, "final_drain", t, 20000);
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
